// File: rtl/timer_cmd_pkg.sv
// timer_cmd_pkg: shared state type and frame/wait constants for timer_cmd_tx
package timer_cmd_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, ACK} state_t;
  localparam logic [3:0] START_PATTERN = 4'b1101;
  localparam int FRAME_W = 8;
  localparam int WAIT_W = 15;
endpackage

// File: rtl/timer_cmd_tx_cmd_shifter.sv
// cmd_shifter: frame register that emits its MSB-first bits on a registered output
module cmd_shifter import timer_cmd_pkg::*; (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               shift,
  input  logic [FRAME_W-1:0] din,
  output logic               q,
  output logic               last
);
  logic [FRAME_W-1:0] sreg;
  logic [3:0] cnt;
  // q already presents bit cnt of the frame, so last marks the 8th bit on the line
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sreg <= '0;
      cnt  <= '0;
      q    <= 1'b0;
    end else if (load) begin
      q    <= din[FRAME_W-1];
      sreg <= {din[FRAME_W-2:0], 1'b0};
      cnt  <= 4'd1;
    end else if (shift) begin
      q    <= sreg[FRAME_W-1];
      sreg <= {sreg[FRAME_W-2:0], 1'b0};
      cnt  <= cnt + 4'd1;
    end else begin
      q    <= 1'b0;
      cnt  <= '0;
    end
  assign last = cnt == 4'(FRAME_W);
endmodule

// File: rtl/timer_cmd_tx.sv
// timer_cmd_tx: sends a delay frame to a timer, waits for done with timeout, then acks
module timer_cmd_tx import timer_cmd_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_delay,
  output logic              data,
  input  logic              done,
  output logic              ack,
  output logic              busy,
  output logic              timeout,
  output logic [WAIT_W-1:0] last_wait
);
  state_t state;
  logic [WAIT_W-1:0] wait_cnt;
  logic last_bit;
  logic accept;
  assign accept = state == IDLE && req_valid && req_ready;
  cmd_shifter u_shifter (
    .clk   (clk),
    .reset_n(reset_n),
    .load  (accept),
    .shift (state == SEND && !last_bit),
    .din   ({START_PATTERN, req_delay}),
    .q     (data),
    .last  (last_bit)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      ack       <= 1'b0;
      timeout   <= 1'b0;
      last_wait <= '0;
      wait_cnt  <= '0;
    end else begin
      ack     <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE:
          if (accept) begin
            state     <= SEND;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end else begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        SEND:
          if (last_bit) begin
            state    <= WAIT_DONE;
            wait_cnt <= WAIT_W'(1);
          end
        WAIT_DONE:
          // done takes priority over the limit in the same cycle
          if (done) begin
            state     <= ACK;
            ack       <= 1'b1;
            last_wait <= wait_cnt;
          end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES)) begin
            state     <= IDLE;
            timeout   <= 1'b1;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else
            wait_cnt <= wait_cnt + WAIT_W'(1);
        ACK: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_timer_cmd_tx.sv
// tb_timer_cmd_tx: scoreboard bench for timer_cmd_tx frames, completion, timeout and reset
module tb_timer_cmd_tx;
  logic clk = 0, reset_n = 0, req_valid = 0, done = 0;
  logic [3:0] req_delay = '0;
  logic req_ready, data, ack, busy, timeout;
  logic [14:0] last_wait;
  int n_cmp = 0, n_err = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  timer_cmd_tx dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_delay(req_delay), .data(data), .done(done), .ack(ack), .busy(busy),
    .timeout(timeout), .last_wait(last_wait)
  );

  task automatic accept(input logic [3:0] d, output int waits);
    logic [7:0] f;
    req_valid = 1;
    req_delay = d;
    waits = 0;
    while (req_ready !== 1'b1 && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL accept_wait: req_ready=%b required 1 after %0d cycles", req_ready, waits);
    end
    f = {4'b1101, d};
    for (int i = 7; i >= 0; i--) exp_q.push_back(f[i]);
    @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    bit e;
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (data !== e || busy !== 1'b1 || req_ready !== 1'b0) begin
        n_err++;
        $display("FAIL %s bit%0d: data=%b busy=%b req_ready=%b required data=%b busy=1 req_ready=0",
                 tag, i, data, busy, req_ready, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic finish_done(input int k_done, input string tag);
    bit bad = 0;
    done = 0;
    n_cmp++;
    if (data !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s wait_start: data=%b busy=%b required data=0 busy=1", tag, data, busy);
    end
    for (int k = 1; k <= k_done; k++) begin
      if (ack !== 1'b0 || timeout !== 1'b0 || busy !== 1'b1 || data !== 1'b0) bad = 1;
      if (k == k_done) done = 1;
      @(negedge clk);
    end
    done = 0;
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL %s waiting: ack/timeout/busy/data misbehaved during wait, required 0/0/1/0", tag);
    end
    n_cmp++;
    if (ack !== 1'b1 || last_wait !== 15'(k_done) || timeout !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s ack: ack=%b last_wait=%0d timeout=%b busy=%b required ack=1 last_wait=%0d timeout=0 busy=1",
               tag, ack, last_wait, timeout, busy, k_done);
    end
  endtask

  task automatic check_idle_after(input string tag);
    @(negedge clk);
    n_cmp++;
    if (ack !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle: ack=%b req_ready=%b busy=%b timeout=%b required 0 1 0 0",
               tag, ack, req_ready, busy, timeout);
    end
  endtask

  task automatic test_reset();
    reset_n = 0;
    #1;
    n_cmp++;
    if ({data, ack, req_ready, busy, timeout} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs: data/ack/req_ready/busy/timeout=%b required 00000",
               {data, ack, req_ready, busy, timeout});
    end
    n_cmp++;
    if (last_wait !== 15'd0) begin
      n_err++;
      $display("FAIL reset_last_wait: last_wait=%0d required 0", last_wait);
    end
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: req_ready=%b busy=%b required 1 0", req_ready, busy);
    end
  endtask

  task automatic test_frame();
    int w;
    accept(4'b0101, w);
    req_valid = 0;
    done = 1;
    check_frame("frame_0101");
    finish_done(6000, "done_6000");
    check_idle_after("done_6000");
  endtask

  task automatic test_timeout();
    int w;
    bit bad = 0;
    accept(4'hA, w);
    req_valid = 0;
    check_frame("frame_A");
    for (int k = 1; k <= 20000; k++) begin
      if (ack !== 1'b0 || timeout !== 1'b0 || busy !== 1'b1) bad = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (bad) begin
      n_err++;
      $display("FAIL timeout_wait: ack/timeout/busy misbehaved before limit");
    end
    n_cmp++;
    if (timeout !== 1'b1 || ack !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || last_wait !== 15'd6000) begin
      n_err++;
      $display("FAIL timeout_pulse: timeout=%b ack=%b busy=%b req_ready=%b last_wait=%0d required 1 0 0 1 6000",
               timeout, ack, busy, req_ready, last_wait);
    end
    @(negedge clk);
    n_cmp++;
    if (timeout !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_once: timeout=%b required 0", timeout);
    end
  endtask

  task automatic test_done_at_limit();
    int w;
    accept(4'h6, w);
    req_valid = 0;
    check_frame("frame_6");
    finish_done(20000, "done_limit");
    check_idle_after("done_limit");
  endtask

  task automatic test_back_to_back();
    int w;
    accept(4'hF, w);
    check_frame("b2b_first");
    finish_done(5, "b2b_first");
    accept(4'h0, w);
    req_valid = 0;
    n_cmp++;
    if (w != 1) begin
      n_err++;
      $display("FAIL b2b_latency: waited %0d cycles required 1", w);
    end
    check_frame("b2b_second");
    finish_done(3, "b2b_second");
    check_idle_after("b2b_second");
  endtask

  task automatic test_reset_mid();
    int w;
    bit e;
    accept(4'hF, w);
    req_valid = 0;
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (data !== e) begin
        n_err++;
        $display("FAIL mid_bit%0d: data=%b required %b", i, data, e);
      end
      if (i == 0) @(negedge clk);
    end
    exp_q.delete();
    reset_n = 0;
    #1;
    n_cmp++;
    if (data !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b0 || ack !== 1'b0 || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: data=%b req_ready=%b busy=%b ack=%b timeout=%b required all 0",
               data, req_ready, busy, ack, timeout);
    end
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    accept(4'h3, w);
    req_valid = 0;
    check_frame("after_reset");
    finish_done(2, "after_reset");
    check_idle_after("after_reset");
  endtask

  initial begin
    test_reset();
    test_frame();
    test_timeout();
    test_done_at_limit();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
